// File: rtl/sat_frame_accumulator_if.sv
// Handshake bundle for sat_frame_accumulator: sample stream in, clamped frame sums out.
// The slave modport is the accumulator's view; master is the surrounding source/sink.
interface sat_frame_accumulator_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 8
);
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_sat;
    logic [CNT_W-1:0]      m_cnt;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_sat, m_cnt
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_sat, m_cnt
    );
endinterface

// File: rtl/sat_frame_accumulator.sv
// Streaming saturating accumulator: sums a frame of signed samples with a per-step clamp,
// emitting one registered result per frame over a valid/ready handshake.
module sat_frame_accumulator #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 8
) (
    input logic                    clk_i,
    input logic                    rst_i,
    sat_frame_accumulator_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {StInit, StAcc, StHold} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sat_q, sat_d;
    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_sat_q, m_sat_d;
    logic [CNT_W-1:0]      m_cnt_q, m_cnt_d;

    logic                  accept;
    logic                  frame_end;
    logic [CNT_W-1:0]      cnt_inc;
    logic [DATA_WIDTH:0]   sum;
    logic                  step_ovf;
    logic [DATA_WIDTH-1:0] step_val;

    localparam logic [DATA_WIDTH-1:0] MaxVal = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    assign accept    = bus.s_valid & s_ready_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign frame_end = accept & (bus.s_last | (cnt_inc == CNT_W'(FRAME_LEN)));

    // Overflow only when both operands share a sign and the narrow result flips it.
    assign sum      = {acc_q[DATA_WIDTH-1], acc_q} + {bus.s_data[DATA_WIDTH-1], bus.s_data};
    assign step_ovf = (acc_q[DATA_WIDTH-1] == bus.s_data[DATA_WIDTH-1]) &&
                      (sum[DATA_WIDTH-1] != acc_q[DATA_WIDTH-1]);
    assign step_val = step_ovf ? (acc_q[DATA_WIDTH-1] ? MinVal : MaxVal) : sum[DATA_WIDTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StInit;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sat_q   <= 1'b0;
            m_cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_sat_q   <= m_sat_d;
            m_cnt_q   <= m_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_sat_d   = m_sat_q;
        m_cnt_d   = m_cnt_q;
        unique case (state_q)
            StInit: begin
                state_d   = StAcc;
                s_ready_d = 1'b1;
            end
            StAcc: begin
                if (accept) begin
                    acc_d = step_val;
                    cnt_d = cnt_inc;
                    sat_d = sat_q | step_ovf;
                end
                if (frame_end) begin
                    m_data_d  = step_val;
                    m_sat_d   = sat_q | step_ovf;
                    m_cnt_d   = cnt_inc;
                    m_valid_d = 1'b1;
                    s_ready_d = 1'b0;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                    acc_d     = '0;
                    cnt_d     = '0;
                    sat_d     = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = StAcc;
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_sat   = m_sat_q;
    assign bus.m_cnt   = m_cnt_q;
endmodule

// File: tb/tb_sat_frame_accumulator.sv
// Directed scoreboard bench for sat_frame_accumulator (DATA_WIDTH=16, FRAME_LEN=4).
module tb_sat_frame_accumulator;
    localparam int unsigned DW = 16;
    localparam int unsigned FL = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
        logic [2:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    sat_frame_accumulator_if #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) bus ();

    sat_frame_accumulator #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives at negedge, holds until a rising edge sees s_ready high.
    task automatic send(input logic [15:0] d, input logic l);
        logic rdy;
        int   n;
        n = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        forever begin
            rdy = bus.s_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = 'x;
        bus.s_last  = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input logic s, input logic [2:0] c);
        exp_t e;
        e.data = d;
        e.sat  = s;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    // Monitor: one pop per output handshake, sampled well clear of both edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("m_data", 32'(bus.m_data), 32'(e.data));
                    chk("m_sat", 32'(bus.m_sat), 32'(e.sat));
                    chk("m_cnt", 32'(bus.m_cnt), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 32'(bus.s_ready), 0);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_data", 32'(bus.m_data), 0);
        chk("rst_m_sat", 32'(bus.m_sat), 0);
        chk("rst_m_cnt", 32'(bus.m_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("init_to_acc_s_ready", 32'(bus.s_ready), 1);

        // 1: plain sum, plus one-cycle latency after last accept
        push(16'd10, 1'b0, 3'd4);
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        idle();
        chk("latency_m_valid", 32'(bus.m_valid), 1);
        chk("hold_s_ready_low", 32'(bus.s_ready), 0);
        drain();

        // 2: positive rail stays clamped
        push(16'h7FFF, 1'b1, 3'd4);
        send(16'h7000, 1'b0);
        send(16'h2000, 1'b0);
        send(16'h0100, 1'b0);
        send(16'h0001, 1'b0);
        idle();
        drain();

        // 3: clamp is per step, later samples pull off the rail
        push(16'hFFFE, 1'b1, 3'd4);
        send(16'h7FFF, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h8000, 1'b0);
        send(16'hFFFF, 1'b0);
        idle();
        drain();

        // 4: negative clamp, early last
        push(16'h8000, 1'b1, 3'd2);
        send(16'h8000, 1'b0);
        send(16'hFFFF, 1'b1);
        idle();
        drain();

        // 5: short frame then full frame from cleared state
        push(16'h0002, 1'b0, 3'd2);
        push(16'h0004, 1'b0, 3'd4);
        send(16'd5, 1'b0);
        send(16'hFFFD, 1'b1);
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        send(16'd1, 1'b1);
        idle();
        drain();

        // 6: backpressure with a pending sample, then reset mid-frame
        @(negedge clk);
        bus.m_ready = 1'b0;
        push(16'd14, 1'b0, 3'd4);
        push(16'd10, 1'b0, 3'd4);
        send(16'd2, 1'b0);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        send(16'd5, 1'b0);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd7;
        bus.s_last  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("stall_s_ready", 32'(bus.s_ready), 0);
            chk("stall_m_valid", 32'(bus.m_valid), 1);
            chk("stall_m_data", 32'(bus.m_data), 14);
        end
        bus.m_ready = 1'b1;
        send(16'd7, 1'b0);
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        idle();
        drain();
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_m_valid", 32'(bus.m_valid), 0);
        chk("async_rst_s_ready", 32'(bus.s_ready), 0);
        bus.s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push(16'd4, 1'b0, 3'd4);
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        idle();
        drain();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
